// File: rtl/ppu_mem_pkg.sv
// ppu_mem_pkg: shared types and constants for the PPU external memory arbiter.
// Address bit 15 selects SRAM (1) or flash (0).
package ppu_mem_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int REGION_BIT = 15;
  localparam int CNT_W      = 4;

  localparam logic [DATA_W-1:0] RDATA_ERR = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_VID
  } grant_t;

  function automatic logic is_sram(input logic [ADDR_W-1:0] addr);
    return addr[REGION_BIT];
  endfunction

endpackage

// File: rtl/ppu_mem_rr_arb.sv
// ppu_mem_rr_arb: two-way round-robin grant between the CPU and video requesters.
// On contention the requester not served last wins; last_grant advances on every take.
module ppu_mem_rr_arb
  import ppu_mem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req,
  input  logic   vid_req,
  input  logic   take,
  output logic   grant_valid,
  output grant_t grant_who
);

  grant_t last_grant_reg;

  always_comb begin
    grant_valid = cpu_req | vid_req;
    grant_who   = GNT_CPU;
    if (cpu_req && vid_req)
      grant_who = (last_grant_reg == GNT_CPU) ? GNT_VID : GNT_CPU;
    else if (vid_req)
      grant_who = GNT_VID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant_reg <= GNT_CPU;
    else if (take && grant_valid)
      last_grant_reg <= grant_who;
  end

endmodule

// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter: shares the PPU flash/SRAM bus between the CPU slave and the video fetcher.
// Each access runs setup / strobe / wait / release with every memory-side output registered.
module ppu_mem_arbiter
  import ppu_mem_pkg::*;
#(
  parameter int WAIT_CYC    = 2,
  parameter int RDY_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mem_be_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              flash_cs_n,
  output logic              sram_cs_n,
  input  logic              mem_rdy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(RDY_TIMEOUT);

  state_t            state_reg;
  grant_t            owner_reg;
  logic              we_reg;
  logic [1:0]        be_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [CNT_W-1:0]  tmo_cnt_reg;

  logic              arb_take;
  logic              grant_valid;
  grant_t            grant_who;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;

  assign arb_take = (state_reg == ST_IDLE);

  ppu_mem_rr_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .vid_req     (vid_req),
    .take        (arb_take),
    .grant_valid (grant_valid),
    .grant_who   (grant_who)
  );

  // Winner's address and direction; the video fetcher only ever reads.
  always_comb begin
    win_addr = cpu_addr;
    win_we   = cpu_we;
    if (grant_who == GNT_VID) begin
      win_addr = vid_addr;
      win_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= GNT_CPU;
      we_reg       <= 1'b0;
      be_reg       <= 2'b00;
      wait_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      cpu_err      <= 1'b0;
      vid_rdata    <= '0;
      vid_ack      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_data_oe  <= 1'b0;
      mem_be_n     <= 2'b11;
      mem_oe_n     <= 1'b1;
      mem_we_n     <= 1'b1;
      flash_cs_n   <= 1'b1;
      sram_cs_n    <= 1'b1;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      vid_ack <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_reg  <= grant_who;
            we_reg     <= win_we;
            be_reg     <= cpu_be;
            mem_addr   <= win_addr;
            flash_cs_n <= is_sram(win_addr);
            sram_cs_n  <= !is_sram(win_addr);
            // Writes to flash never reach the pins, so the data bus stays released.
            mem_data_oe <= win_we && is_sram(win_addr);
            if (grant_who == GNT_CPU)
              mem_wdata <= cpu_wdata;
            state_reg <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (we_reg && !is_sram(mem_addr)) begin
            flash_cs_n <= 1'b1;
            sram_cs_n  <= 1'b1;
            cpu_ack    <= 1'b1;
            cpu_err    <= 1'b1;
            state_reg  <= ST_RELEASE;
          end else begin
            wait_cnt_reg <= WAIT_LOAD;
            tmo_cnt_reg  <= '0;
            if (we_reg) begin
              mem_we_n <= 1'b0;
              mem_be_n <= ~be_reg;
            end else begin
              mem_oe_n <= 1'b0;
              mem_be_n <= 2'b00;
            end
            state_reg <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          if (wait_cnt_reg != '0) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end else if (mem_rdy || tmo_cnt_reg == TMO_LAST) begin
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_be_n   <= 2'b11;
            flash_cs_n <= 1'b1;
            sram_cs_n  <= 1'b1;
            if (owner_reg == GNT_CPU) begin
              cpu_ack <= 1'b1;
              cpu_err <= !mem_rdy;
              if (!mem_rdy)
                cpu_rdata <= RDATA_ERR;
              else if (!we_reg)
                cpu_rdata <= mem_rdata;
            end else begin
              vid_ack   <= 1'b1;
              vid_rdata <= mem_rdy ? mem_rdata : RDATA_ERR;
            end
            state_reg <= ST_RELEASE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end

        ST_RELEASE: begin
          // Write data was held through this cycle for hold time.
          mem_data_oe <= 1'b0;
          state_reg   <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter: directed plus randomized accesses against a transaction-level model
// of the arbiter (round-robin order, access latency, strobe length, data and error results).
module tb_ppu_mem_arbiter;

  localparam int WAIT_CYC    = 2;
  localparam int RDY_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        vid_req;
  logic [15:0] vid_addr, vid_rdata;
  logic        vid_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_oe;
  logic [1:0]  mem_be_n;
  logic        mem_oe_n, mem_we_n, flash_cs_n, sram_cs_n, mem_rdy;

  always #5 clk = ~clk;

  ppu_mem_arbiter #(.WAIT_CYC(WAIT_CYC), .RDY_TIMEOUT(RDY_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
    .mem_rdata(mem_rdata), .mem_be_n(mem_be_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .flash_cs_n(flash_cs_n), .sram_cs_n(sram_cs_n), .mem_rdy(mem_rdy)
  );

  typedef struct {
    bit          is_vid;
    bit          we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          d;      // cycles mem_rdy lags the last wait cycle
  } op_t;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] pin_mem [32];  // contents seen at the pins
  logic [15:0] ref_mem [32];  // contents the model expects
  bit          last_vid;      // model: last requester granted

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int midx(input logic [15:0] a);
    return int'({a[15], a[3:0]});
  endfunction

  function automatic bit flash_wr(input op_t o);
    return o.we && !o.addr[15];
  endfunction

  function automatic int exp_strobe(input op_t o);
    if (flash_wr(o)) return 0;
    return WAIT_CYC + ((o.d <= RDY_TIMEOUT) ? o.d : RDY_TIMEOUT);
  endfunction

  function automatic bit exp_tmo(input op_t o);
    return !flash_wr(o) && (o.d > RDY_TIMEOUT);
  endfunction

  function automatic op_t mk(input bit vid, input bit we, input logic [1:0] be,
                             input logic [15:0] addr, input logic [15:0] wdata, input int d);
    op_t o;
    o.is_vid = vid; o.we = we; o.be = be; o.addr = addr; o.wdata = wdata; o.d = d;
    return o;
  endfunction

  function automatic op_t rand_op(input bit vid);
    int r;
    op_t o;
    o.is_vid = vid;
    o.we     = vid ? 1'b0 : ($urandom_range(0, 2) == 0);
    o.be     = 2'($urandom_range(1, 3));
    o.addr   = {($urandom_range(0, 3) != 0), 15'($urandom)};
    o.wdata  = 16'($urandom);
    r = $urandom_range(0, 9);
    o.d = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 4) : $urandom_range(16, 20);
    return o;
  endfunction

  // Called right after a negedge with the DUT idle; runs one or two accesses to completion.
  task automatic run_scn(input bit use_c, input bit use_v, input op_t cop, input op_t vop);
    op_t ord[2];
    op_t o;
    int n = 1, cyc = 0, base = 0, idx = 0, strb = 0, doe = 0, exp_doe;
    logic [1:0]  be_exp;
    logic [15:0] rd_exp;
    bit          tmo;
    if (use_c && use_v) begin
      n = 2;
      if (last_vid) begin ord[0] = cop; ord[1] = vop; end
      else          begin ord[0] = vop; ord[1] = cop; end
    end else if (use_c) ord[0] = cop;
    else                ord[0] = vop;

    if (use_c) begin
      cpu_req = 1'b1; cpu_we = cop.we; cpu_be = cop.be;
      cpu_addr = cop.addr; cpu_wdata = cop.wdata;
    end
    if (use_v) begin
      vid_req = 1'b1; vid_addr = vop.addr;
    end

    while (idx < n && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      o = ord[idx];
      if (mem_data_oe) doe++;
      mem_rdy   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (!mem_oe_n || !mem_we_n) begin
        strb++;
        check_eq("strb_addr", mem_addr, o.addr);
        check_eq("strb_cs", {flash_cs_n, sram_cs_n}, o.addr[15] ? 2'b10 : 2'b01);
        if (!mem_we_n) begin
          be_exp = ~o.be;
          check_eq("be_n", mem_be_n, be_exp);
          check_eq("wdata", mem_wdata, o.wdata);
          if (!mem_be_n[0]) pin_mem[midx(mem_addr)][7:0]  = mem_wdata[7:0];
          if (!mem_be_n[1]) pin_mem[midx(mem_addr)][15:8] = mem_wdata[15:8];
        end else begin
          mem_rdata = pin_mem[midx(mem_addr)];
        end
        mem_rdy = (strb >= WAIT_CYC + o.d);
      end
      if (cpu_ack || vid_ack) begin
        tmo = exp_tmo(o);
        check_eq("ack_who", {cpu_ack, vid_ack}, o.is_vid ? 2'b01 : 2'b10);
        check_eq("ack_lat", cyc - base,
                 (flash_wr(o) ? 2 : 2 + exp_strobe(o)) + ((idx > 0) ? 1 : 0));
        check_eq("strb_len", strb, exp_strobe(o));
        exp_doe = (o.we && o.addr[15]) ? exp_strobe(o) + 2 : 0;
        check_eq("data_oe_len", doe, exp_doe);
        rd_exp = tmo ? 16'hFFFF : ref_mem[midx(o.addr)];
        if (o.is_vid) begin
          check_eq("vid_rdata", vid_rdata, rd_exp);
        end else begin
          check_eq("cpu_err", cpu_err, tmo || flash_wr(o));
          if (!o.we || tmo) check_eq("cpu_rdata", cpu_rdata, rd_exp);
        end
        if (o.we && o.addr[15]) begin
          if (o.be[0]) ref_mem[midx(o.addr)][7:0]  = o.wdata[7:0];
          if (o.be[1]) ref_mem[midx(o.addr)][15:8] = o.wdata[15:8];
        end
        last_vid = o.is_vid;
        if (o.is_vid) vid_req = 1'b0; else cpu_req = 1'b0;
        $display("txn %s we=%0b addr=%h d=%0d lat=%0d strobe=%0d", o.is_vid ? "VID" : "CPU",
                 o.we, o.addr, o.d, cyc - base, strb);
        idx++; base = cyc; strb = 0; doe = 0;
      end
    end
    check_eq("ack_seen", idx, n);
    cpu_req = 1'b0; vid_req = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
    check_eq("idle_pins", {flash_cs_n, sram_cs_n, mem_oe_n, mem_we_n, mem_data_oe, cpu_ack, vid_ack},
             7'b1111000);
  endtask

  op_t nop;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0; mem_rdata = 16'hDEAD; mem_rdy = 1'b0;
    last_vid = 1'b0;
    nop = mk(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 0);
    for (int i = 0; i < 32; i++) begin
      pin_mem[i] = 16'((i * 4951) ^ 50085);
      ref_mem[i] = pin_mem[i];
    end
    pin_mem[midx(16'h8010)] = 16'h1234;
    ref_mem[midx(16'h8010)] = 16'h1234;

    repeat (3) @(negedge clk);
    check_eq("rst_ctl", {cpu_ack, cpu_err, vid_ack, mem_data_oe}, 4'b0000);
    check_eq("rst_n", {mem_be_n, mem_oe_n, mem_we_n, flash_cs_n, sram_cs_n}, 6'h3F);
    check_eq("rst_data", {cpu_rdata, vid_rdata}, 32'h0);
    check_eq("rst_addr", mem_addr, 16'h0);
    reset = 1'b0;

    // Directed cases
    run_scn(1'b1, 1'b0, mk(1'b0, 1'b0, 2'b00, 16'h8010, 16'h0, 0), nop);
    run_scn(1'b1, 1'b0, mk(1'b0, 1'b1, 2'b10, 16'h8002, 16'hBEEF, 0), nop);
    run_scn(1'b1, 1'b1, mk(1'b0, 1'b0, 2'b00, 16'h8002, 16'h0, 0),
            mk(1'b1, 1'b0, 2'b00, 16'h0007, 16'h0, 0));
    run_scn(1'b1, 1'b1, mk(1'b0, 1'b0, 2'b00, 16'h0003, 16'h0, 0),
            mk(1'b1, 1'b0, 2'b00, 16'h8010, 16'h0, 0));
    run_scn(1'b1, 1'b0, mk(1'b0, 1'b1, 2'b11, 16'h0100, 16'h5555, 0), nop);
    run_scn(1'b1, 1'b0, mk(1'b0, 1'b0, 2'b00, 16'h8004, 16'h0, 20), nop);
    run_scn(1'b1, 1'b0, mk(1'b0, 1'b0, 2'b00, 16'h8004, 16'h0, 3), nop);
    run_scn(1'b0, 1'b1, nop, mk(1'b1, 1'b0, 2'b00, 16'h8005, 16'h0, 18));

    // Reset during the strobe of an SRAM write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'h800C; cpu_wdata = 16'hA5A5;
    for (int i = 0; i < 8 && mem_we_n; i++) @(negedge clk);
    check_eq("rst_pre_we_n", mem_we_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_pins", {mem_we_n, mem_oe_n, flash_cs_n, sram_cs_n, mem_data_oe, mem_be_n},
             7'b1111011);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_vid = 1'b0;
    run_scn(1'b1, 1'b1, mk(1'b0, 1'b0, 2'b00, 16'h8010, 16'h0, 0),
            mk(1'b1, 1'b0, 2'b00, 16'h0001, 16'h0, 1));

    // Randomized traffic
    for (int s = 0; s < 40; s++) begin
      int sel;
      sel = $urandom_range(0, 2);
      run_scn(sel != 1, sel != 0, rand_op(1'b0), rand_op(1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
